// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared sizes and entry layout for the instruction queue
//
// Purpose: queue depth, pointer width, field widths and the packed entry type
//          used by the queue top, its storage array and its interface.
// Ports:   none (package).

package inst_queue_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_PTR_W = 4;
  localparam int PC_W     = 32;
  localparam int INST_W   = 32;
  localparam int ENTRY_W  = 1 + PC_W + INST_W;

  // Entry packing {adel, pc, inst}, 65 bits
  typedef struct packed {
    logic              adel;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode side signals of the instruction queue
//
// Purpose: bundles the fetch (enqueue) slots, the decode (dequeue) slots,
//          flush, full and count.
// Modports:
//   master - fetch/decode side: drives flush, in_*, deq_*; sees full, out_*, count
//   slave  - the queue: the reverse

interface inst_queue_if import inst_queue_pkg::*; #(
  parameter int PTR_W = IQ_PTR_W
);

  logic              flush;
  logic              in_valid_1;
  logic              in_valid_2;
  logic [PC_W-1:0]   in_pc_1;
  logic [PC_W-1:0]   in_pc_2;
  logic [INST_W-1:0] in_inst_1;
  logic [INST_W-1:0] in_inst_2;
  logic              in_adel_1;
  logic              in_adel_2;
  logic              full;
  logic              out_valid_1;
  logic              out_valid_2;
  logic [PC_W-1:0]   out_pc_1;
  logic [PC_W-1:0]   out_pc_2;
  logic [INST_W-1:0] out_inst_1;
  logic [INST_W-1:0] out_inst_2;
  logic              out_adel_1;
  logic              out_adel_2;
  logic              deq_1;
  logic              deq_2;
  logic [PTR_W:0]    count;

  modport master (
    output flush, in_valid_1, in_valid_2, in_pc_1, in_pc_2,
           in_inst_1, in_inst_2, in_adel_1, in_adel_2, deq_1, deq_2,
    input  full, out_valid_1, out_valid_2, out_pc_1, out_pc_2,
           out_inst_1, out_inst_2, out_adel_1, out_adel_2, count
  );

  modport slave (
    input  flush, in_valid_1, in_valid_2, in_pc_1, in_pc_2,
           in_inst_1, in_inst_2, in_adel_1, in_adel_2, deq_1, deq_2,
    output full, out_valid_1, out_valid_2, out_pc_1, out_pc_2,
           out_inst_1, out_inst_2, out_adel_1, out_adel_2, count
  );

endinterface

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - entry storage, two sync write ports, two async read ports
//
// Purpose: DEPTH x 65-bit register array; not reset.
// Ports:
//   clk               clock
//   we_1/waddr_1/wdata_1  write port 1 (tail)
//   we_2/waddr_2/wdata_2  write port 2 (tail+1); never aliases port 1
//   raddr_1/rdata_1   async read port 1 (head)
//   raddr_2/rdata_2   async read port 2 (head+1)

module inst_queue_ram import inst_queue_pkg::*; #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W
) (
  input  logic             clk,
  input  logic             we_1,
  input  logic [PTR_W-1:0] waddr_1,
  input  iq_entry_t        wdata_1,
  input  logic             we_2,
  input  logic [PTR_W-1:0] waddr_2,
  input  iq_entry_t        wdata_2,
  input  logic [PTR_W-1:0] raddr_1,
  output iq_entry_t        rdata_1,
  input  logic [PTR_W-1:0] raddr_2,
  output iq_entry_t        rdata_2
);

  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_1) mem[waddr_1] <= wdata_1;
    if (we_2) mem[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction buffer between fetch and decode
//
// Purpose: circular buffer taking 0-2 fetched instructions per cycle and
//          presenting the oldest two to decode (first-word-fall-through).
// Ports:
//   clk     clock
//   resetn  synchronous active-low reset (priority over flush)
//   q       inst_queue_if.slave: fetch slots, decode slots, flush, full, count

module inst_queue import inst_queue_pkg::*; #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  q
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full_w;
  logic             valid_1;
  logic             valid_2;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  iq_entry_t        wdata_1;
  iq_entry_t        wdata_2;
  iq_entry_t        rdata_1;
  iq_entry_t        rdata_2;

  // Gating uses the registered count only, so a dequeue this cycle never
  // makes room for an enqueue this cycle.
  assign full_w  = (count > CNT_W'(DEPTH - 2));
  assign valid_1 = (count != '0);
  assign valid_2 = (count >= CNT_W'(2));

  // Slot 2 counts only behind slot 1; likewise deq_2 only behind deq_1.
  assign n_enq = (full_w || !q.in_valid_1) ? 2'd0 : (q.in_valid_2 ? 2'd2 : 2'd1);
  assign n_deq = !(q.deq_1 && valid_1) ? 2'd0 : ((q.deq_2 && valid_2) ? 2'd2 : 2'd1);

  assign wdata_1 = '{adel: q.in_adel_1, pc: q.in_pc_1, inst: q.in_inst_1};
  assign wdata_2 = '{adel: q.in_adel_2, pc: q.in_pc_2, inst: q.in_inst_2};

  inst_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk     (clk),
    .we_1    (!q.flush && n_enq != 2'd0),
    .waddr_1 (tail),
    .wdata_1 (wdata_1),
    .we_2    (!q.flush && n_enq == 2'd2),
    .waddr_2 (tail + PTR_W'(1)),
    .wdata_2 (wdata_2),
    .raddr_1 (head),
    .rdata_1 (rdata_1),
    .raddr_2 (head + PTR_W'(1)),
    .rdata_2 (rdata_2)
  );

  always_ff @(posedge clk) begin
    if (!resetn || q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  assign q.full        = full_w;
  assign q.count       = count;
  assign q.out_valid_1 = valid_1;
  assign q.out_valid_2 = valid_2;
  assign q.out_pc_1    = rdata_1.pc;
  assign q.out_pc_2    = rdata_2.pc;
  assign q.out_inst_1  = rdata_1.inst;
  assign q.out_inst_2  = rdata_2.inst;
  assign q.out_adel_1  = rdata_1.adel;
  assign q.out_adel_2  = rdata_2.adel;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue

module tb_inst_queue;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  inst_queue_if qif ();

  inst_queue dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qif)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    qif.flush      = 1'b0;
    qif.in_valid_1 = 1'b0;
    qif.in_valid_2 = 1'b0;
    qif.in_pc_1    = '0;
    qif.in_pc_2    = '0;
    qif.in_inst_1  = '0;
    qif.in_inst_2  = '0;
    qif.in_adel_1  = 1'b0;
    qif.in_adel_2  = 1'b0;
    qif.deq_1      = 1'b0;
    qif.deq_2      = 1'b0;
  endtask

  task automatic enq(input logic v1, input logic v2, input logic [31:0] pc1,
                     input logic [31:0] pc2, input logic a1, input logic a2);
    qif.in_valid_1 = v1;
    qif.in_valid_2 = v2;
    qif.in_pc_1    = pc1;
    qif.in_pc_2    = pc2;
    qif.in_inst_1  = pc1 ^ 32'hA5A5_0000;
    qif.in_inst_2  = pc2 ^ 32'hA5A5_0000;
    qif.in_adel_1  = a1;
    qif.in_adel_2  = a2;
  endtask

  task automatic do_reset;
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    total++; if (qif.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", qif.count); end
    total++; if (qif.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", qif.full); end
    total++; if (qif.out_valid_1 !== 1'b0) begin bad++; $display("FAIL reset_v1 got=%b exp=0", qif.out_valid_1); end
    total++; if (qif.out_valid_2 !== 1'b0) begin bad++; $display("FAIL reset_v2 got=%b exp=0", qif.out_valid_2); end
  endtask

  task automatic test_basic;
    do_reset();
    enq(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0004, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (qif.count !== 5'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", qif.count); end
    total++; if (qif.out_valid_1 !== 1'b1 || qif.out_valid_2 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b%b exp=11", qif.out_valid_1, qif.out_valid_2); end
    total++; if (qif.out_pc_1 !== 32'hBFC0_0000) begin bad++; $display("FAIL basic_pc1 got=%h exp=bfc00000", qif.out_pc_1); end
    total++; if (qif.out_pc_2 !== 32'hBFC0_0004) begin bad++; $display("FAIL basic_pc2 got=%h exp=bfc00004", qif.out_pc_2); end
    total++; if (qif.out_inst_2 !== 32'h1A65_0004) begin bad++; $display("FAIL basic_inst2 got=%h exp=1a650004", qif.out_inst_2); end
  endtask

  task automatic test_fill_pairs;
    int exp_cnt;
    exp_cnt = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      enq(1'b1, 1'b1, 32'h400 + 32'(8 * i), 32'h404 + 32'(8 * i), 1'b0, 1'b0);
      tick();
      if (exp_cnt <= 14) exp_cnt += 2;
      total++; if (qif.count !== 5'(exp_cnt)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, qif.count, exp_cnt); end
      total++; if (qif.full !== (exp_cnt > 14)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, qif.full, exp_cnt > 14); end
    end
    idle();
    total++; if (qif.out_pc_1 !== 32'h400) begin bad++; $display("FAIL fill_head got=%h exp=400", qif.out_pc_1); end
    total++; if (qif.out_valid_2 !== 1'b1) begin bad++; $display("FAIL fill_v2 got=%b exp=1", qif.out_valid_2); end
  endtask

  task automatic test_full_deq;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      enq(1'b1, 1'b1, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 1'b0, 1'b0);
      tick();
    end
    enq(1'b1, 1'b0, 32'h138, 32'h0, 1'b0, 1'b0);
    tick();
    total++; if (qif.count !== 5'd15) begin bad++; $display("FAIL fd_count15 got=%0d exp=15", qif.count); end
    total++; if (qif.full !== 1'b1) begin bad++; $display("FAIL fd_full got=%b exp=1", qif.full); end
    enq(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b0);
    qif.deq_1 = 1'b1;
    qif.deq_2 = 1'b1;
    tick();
    qif.deq_1 = 1'b0;
    qif.deq_2 = 1'b0;
    total++; if (qif.count !== 5'd13) begin bad++; $display("FAIL fd_count13 got=%0d exp=13", qif.count); end
    total++; if (qif.full !== 1'b0) begin bad++; $display("FAIL fd_notfull got=%b exp=0", qif.full); end
    enq(1'b1, 1'b1, 32'h13C, 32'h140, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (qif.count !== 5'd15) begin bad++; $display("FAIL fd_refill got=%0d exp=15", qif.count); end
    // Dropped pair must not appear anywhere in the drained sequence
    for (int i = 0; i < 15; i++) begin
      total++; if (qif.out_pc_1 !== 32'h108 + 32'(4 * i)) begin bad++; $display("FAIL fd_drain[%0d] got=%h exp=%h", i, qif.out_pc_1, 32'h108 + 32'(4 * i)); end
      qif.deq_1 = 1'b1;
      tick();
    end
    qif.deq_1 = 1'b0;
    total++; if (qif.count !== 5'd0) begin bad++; $display("FAIL fd_empty got=%0d exp=0", qif.count); end
  endtask

  task automatic test_wrap;
    logic [31:0] base;
    do_reset();
    for (int r = 0; r < 20; r++) begin
      base = 32'h1000 + 32'(8 * r);
      enq(1'b1, 1'b1, base, base + 32'd4, 1'b0, 1'b0);
      qif.deq_1 = (r > 0);
      qif.deq_2 = (r > 0);
      if (r > 0) begin
        total++; if (qif.out_pc_1 !== base - 32'd8) begin bad++; $display("FAIL wrap_pc1[%0d] got=%h exp=%h", r, qif.out_pc_1, base - 32'd8); end
        total++; if (qif.out_pc_2 !== base - 32'd4) begin bad++; $display("FAIL wrap_pc2[%0d] got=%h exp=%h", r, qif.out_pc_2, base - 32'd4); end
      end
      tick();
      total++; if (qif.count !== 5'd2) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=2", r, qif.count); end
    end
    idle();
    total++; if (qif.out_pc_1 !== 32'h1098) begin bad++; $display("FAIL wrap_last got=%h exp=1098", qif.out_pc_1); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq(1'b1, 1'b1, 32'h500 + 32'(8 * i), 32'h504 + 32'(8 * i), 1'b0, 1'b0);
      tick();
    end
    total++; if (qif.count !== 5'd6) begin bad++; $display("FAIL fl_count6 got=%0d exp=6", qif.count); end
    enq(1'b1, 1'b1, 32'h600, 32'h604, 1'b0, 1'b0);
    qif.deq_1 = 1'b1;
    qif.deq_2 = 1'b1;
    qif.flush = 1'b1;
    tick();
    idle();
    total++; if (qif.count !== 5'd0) begin bad++; $display("FAIL fl_count0 got=%0d exp=0", qif.count); end
    total++; if (qif.out_valid_1 !== 1'b0) begin bad++; $display("FAIL fl_v1 got=%b exp=0", qif.out_valid_1); end
    enq(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (qif.out_pc_1 !== 32'h2000) begin bad++; $display("FAIL fl_pc got=%h exp=2000", qif.out_pc_1); end
    total++; if (qif.count !== 5'd1 || qif.out_valid_2 !== 1'b0) begin bad++; $display("FAIL fl_after got=%0d/%b exp=1/0", qif.count, qif.out_valid_2); end
  endtask

  task automatic test_odd;
    do_reset();
    enq(1'b0, 1'b1, 32'h0, 32'h700, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (qif.count !== 5'd0) begin bad++; $display("FAIL odd_v2only got=%0d exp=0", qif.count); end
    qif.deq_1 = 1'b1;
    qif.deq_2 = 1'b1;
    tick();
    idle();
    total++; if (qif.count !== 5'd0) begin bad++; $display("FAIL odd_deq_empty got=%0d exp=0", qif.count); end
    enq(1'b1, 1'b1, 32'h3000, 32'h3004, 1'b0, 1'b1);
    tick();
    idle();
    total++; if (qif.out_adel_1 !== 1'b0 || qif.out_adel_2 !== 1'b1) begin bad++; $display("FAIL odd_adel got=%b%b exp=01", qif.out_adel_1, qif.out_adel_2); end
    qif.deq_2 = 1'b1;
    tick();
    idle();
    total++; if (qif.count !== 5'd2) begin bad++; $display("FAIL odd_deq2only got=%0d exp=2", qif.count); end
    qif.deq_1 = 1'b1;
    tick();
    idle();
    total++; if (qif.count !== 5'd1) begin bad++; $display("FAIL odd_deq1 got=%0d exp=1", qif.count); end
    total++; if (qif.out_adel_1 !== 1'b1 || qif.out_pc_1 !== 32'h3004) begin bad++; $display("FAIL odd_adel_head got=%b/%h exp=1/3004", qif.out_adel_1, qif.out_pc_1); end
    for (int i = 0; i < 4; i++) begin
      enq(1'b1, 1'b1, 32'h3100 + 32'(8 * i), 32'h3104 + 32'(8 * i), 1'b0, 1'b0);
      tick();
    end
    idle();
    total++; if (qif.count !== 5'd9) begin bad++; $display("FAIL odd_count9 got=%0d exp=9", qif.count); end
    resetn = 1'b0;
    qif.flush = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (qif.count !== 5'd0 || qif.out_valid_1 !== 1'b0) begin bad++; $display("FAIL odd_reset got=%0d/%b exp=0/0", qif.count, qif.out_valid_1); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill_pairs();
    test_full_deq();
    test_wrap();
    test_flush();
    test_odd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
